// File: rtl/hex_display_unit.sv
// Clock housekeeping and memory-mapped display block: emulated PLL lock/reset pair,
// store-addressed HEX and LEDR registers, and six active-low seven-segment digits.
module hex_display_unit #(
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [31:0] ADDRHEX     = 32'hFFFFF000,
  parameter logic [31:0] ADDRLEDR    = 32'hFFFFF020,
  parameter logic [23:0] HEX_RESET   = 24'hFEDEAD
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [5:0]  blank,
  output logic        locked,
  output logic        reset_out,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [9:0]  LEDR
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             locked_r;
  logic             reset_out_r;
  logic [23:0]      hex_r;
  logic [9:0]       ledr_r;
  logic             hex_wr_s;
  logic             ledr_wr_s;
  logic [6:0]       digit_s [6];
  logic             unused_data_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign cnt_next_s    = cnt_r + CNT_W'(1);
  assign hex_wr_s      = wr_en && (wr_addr == ADDRHEX);
  assign ledr_wr_s     = wr_en && (wr_addr == ADDRLEDR);
  assign unused_data_s = ^wr_data[31:24];

  // Lock counter: counts edges after release, asserts lock on reaching target, then holds.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r       <= '0;
      locked_r    <= 1'b0;
      reset_out_r <= 1'b1;
    end else if (!locked_r) begin
      cnt_r <= cnt_next_s;
      if (cnt_next_s == LOCK_TARGET) begin
        locked_r    <= 1'b1;
        reset_out_r <= 1'b0;
      end else begin
        locked_r    <= 1'b0;
        reset_out_r <= 1'b1;
      end
    end else begin
      cnt_r       <= cnt_r;
      locked_r    <= 1'b1;
      reset_out_r <= 1'b0;
    end
  end

  // Display registers: held at their reset values until locked, then loaded by stores.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hex_r  <= HEX_RESET;
      ledr_r <= 10'h000;
    end else if (!locked_r) begin
      hex_r  <= HEX_RESET;
      ledr_r <= 10'h000;
    end else begin
      if (hex_wr_s) begin
        hex_r <= wr_data[23:0];
      end
      if (ledr_wr_s) begin
        ledr_r <= wr_data[9:0];
      end
    end
  end

  // Per-digit decode with blanking; combinational so a write shows on the next edge.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      digit_s[i] = 7'h7F;
      if (blank[i]) begin
        digit_s[i] = 7'h7F;
      end else begin
        digit_s[i] = seg_decode(hex_r[4*i +: 4]);
      end
    end
  end

  assign locked    = locked_r;
  assign reset_out = reset_out_r;
  assign LEDR      = ledr_r;
  assign HEX0      = digit_s[0];
  assign HEX1      = digit_s[1];
  assign HEX2      = digit_s[2];
  assign HEX3      = digit_s[3];
  assign HEX4      = digit_s[4];
  assign HEX5      = digit_s[5];

endmodule

// File: tb/tb_hex_display_unit.sv
// Self-checking bench for hex_display_unit: directed scenarios plus randomized stores
// compared against a value-level model of the display and lock behaviour.
module tb_hex_display_unit;

  localparam int          LOCK     = 16;
  localparam logic [31:0] A_HEX    = 32'hFFFFF000;
  localparam logic [31:0] A_LEDR   = 32'hFFFFF020;
  localparam logic [41:0] FEDEAD_S = {7'h0E, 7'h06, 7'h21, 7'h06, 7'h08, 7'h21};

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        wr_en    = 1'b0;
  logic [31:0] wr_addr  = 32'h0;
  logic [31:0] wr_data  = 32'h0;
  logic [5:0]  blank    = 6'h0;
  logic        locked, reset_out;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0]  LEDR;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_edges = 0;
  logic [23:0] m_hex   = 24'hFEDEAD;
  logic [9:0]  m_led   = 10'h0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_unit dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .blank(blank), .locked(locked), .reset_out(reset_out),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .LEDR(LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [41:0] exp_digits(input logic [23:0] v, input logic [5:0] bl);
    logic [41:0] r;
    for (int i = 0; i < 6; i++) begin
      r[7*i +: 7] = bl[i] ? 7'h7F : seg_tbl[(v >> (4*i)) & 24'hF];
    end
    return r;
  endfunction

  function automatic logic [41:0] act_digits();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  // Advance one rising edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    if (m_edges >= LOCK) begin
      if (wr_en && wr_addr == A_HEX)  m_hex = wr_data[23:0];
      if (wr_en && wr_addr == A_LEDR) m_led = wr_data[9:0];
    end else begin
      m_hex = 24'hFEDEAD;
      m_led = 10'h0;
    end
    if (m_edges < LOCK) m_edges++;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    total++; if (reset_out !== 1'b1) begin bad++; $display("FAIL reset_out got=%b want=1", reset_out); end
    total++; if (act_digits() !== FEDEAD_S) begin bad++; $display("FAIL reset_hex got=%h want=%h", act_digits(), FEDEAD_S); end
    total++; if (LEDR !== 10'h0) begin bad++; $display("FAIL reset_ledr got=%h want=000", LEDR); end
  endtask

  // Release reset and count edges; stores during the unlocked window must be ignored.
  task automatic test_lock(input string tag);
    @(posedge CLOCK_50); #1;
    RESET_N = 1'b1;
    m_edges = 0; m_hex = 24'hFEDEAD; m_led = 10'h0;
    for (int k = 1; k <= LOCK; k++) begin
      wr_en = 1'b1; wr_addr = (k % 2 == 0) ? A_HEX : A_LEDR; wr_data = $urandom;
      tick();
      total++;
      if (locked !== (k >= LOCK) || reset_out !== (k < LOCK)) begin
        bad++; $display("FAIL %s_edge%0d locked=%b reset_out=%b want_locked=%b", tag, k, locked, reset_out, k >= LOCK);
      end
      total++;
      if (act_digits() !== FEDEAD_S || LEDR !== 10'h0) begin
        bad++; $display("FAIL %s_unlocked_disp%0d hex=%h ledr=%h want=%h/000", tag, k, act_digits(), LEDR, FEDEAD_S);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_directed();
    store(A_HEX, 32'h00123456);
    total++; if (act_digits() !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin bad++; $display("FAIL store_123456 got=%h", act_digits()); end
    store(A_LEDR, 32'hFFFFFFFF);
    total++; if (LEDR !== 10'h3FF) begin bad++; $display("FAIL ledr_3ff got=%h want=3ff", LEDR); end
    total++; if (act_digits() !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin bad++; $display("FAIL hex_unchanged got=%h", act_digits()); end
    store(A_LEDR + 32'h4, 32'h00000000);
    total++; if (LEDR !== 10'h3FF) begin bad++; $display("FAIL ledr_near_addr got=%h want=3ff", LEDR); end
    store(A_HEX, 32'h89ABCDEF);
    total++; if (act_digits() !== {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}) begin bad++; $display("FAIL store_abcdef got=%h", act_digits()); end
    blank = 6'b000001; #1;
    total++; if (HEX0 !== 7'h7F || HEX1 !== 7'h06) begin bad++; $display("FAIL blank0 hex0=%h hex1=%h want=7f/06", HEX0, HEX1); end
    blank = 6'b100000; #1;
    total++; if (HEX5 !== 7'h7F || HEX0 !== 7'h0E) begin bad++; $display("FAIL blank5 hex5=%h hex0=%h want=7f/0e", HEX5, HEX0); end
    blank = 6'b000000;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      wr_en = 1'b1; wr_addr = (k < 3) ? A_HEX : A_LEDR; wr_data = d;
      tick();
      total++;
      if (act_digits() !== exp_digits(m_hex, blank) || LEDR !== m_led) begin
        bad++; $display("FAIL b2b%0d hex=%h ledr=%h want=%h/%h", k, act_digits(), LEDR, exp_digits(m_hex, blank), m_led);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_random(input int n);
    int sel;
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 3);
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_addr = (sel == 0) ? A_HEX : (sel == 1) ? A_LEDR : (sel == 2) ? (A_HEX ^ (32'h1 << $urandom_range(0, 31))) : $urandom;
      wr_data = $urandom;
      blank   = 6'($urandom_range(0, 63));
      tick();
      total++;
      if (act_digits() !== exp_digits(m_hex, blank) || LEDR !== m_led || locked !== 1'b1) begin
        bad++; $display("FAIL rand%0d hex=%h ledr=%h locked=%b want=%h/%h/1", k, act_digits(), LEDR, locked, exp_digits(m_hex, blank), m_led);
      end
    end
    wr_en = 1'b0; blank = 6'h0;
  endtask

  task automatic test_midrun_reset();
    store(A_LEDR, 32'h000002A5);
    store(A_HEX, 32'h00C0FFEE);
    total++; if (LEDR !== 10'h2A5) begin bad++; $display("FAIL pre_reset_ledr got=%h want=2a5", LEDR); end
    #2;
    RESET_N = 1'b0;
    #1;
    total++; if (locked !== 1'b0 || reset_out !== 1'b1) begin bad++; $display("FAIL midrun_lock locked=%b reset_out=%b", locked, reset_out); end
    total++; if (act_digits() !== FEDEAD_S) begin bad++; $display("FAIL midrun_hex got=%h want=%h", act_digits(), FEDEAD_S); end
    total++; if (LEDR !== 10'h0) begin bad++; $display("FAIL midrun_ledr got=%h want=000", LEDR); end
    @(posedge CLOCK_50); #1;
    test_lock("relock");
  endtask

  initial begin
    test_reset();
    test_lock("lock");
    test_directed();
    test_back_to_back();
    test_random(300);
    test_midrun_reset();
    test_directed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
